// File: rtl/spi_meas_reader_pkg.sv
// -----------------------------------------------------------------------------
// meas_pkg: definitions shared by the SPI measurement reader.
//   - meas_state_e : reader FSM state encoding
//   - FRAME_BITS   : bits per SPI read frame (four 32-bit words)
//   - WORD_W       : width of one measurement word
//   - FX/FBASE/TIME/DUTY : word positions in the frame, first-sent first
//   - frame_word() : extracts word N from a frame (word 0 in the MSBs)
// -----------------------------------------------------------------------------
package meas_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StArm,
      StCsLead,
      StShift,
      StCsTrail,
      StDone
   } meas_state_e;

   localparam int unsigned FRAME_BITS = 128;
   localparam int unsigned WORD_W     = 32;

   localparam int unsigned FX    = 0;
   localparam int unsigned FBASE = 1;
   localparam int unsigned TIME  = 2;
   localparam int unsigned DUTY  = 3;

   // Word 0 arrives first and the frame is shifted in MSB-first, so it lands on top.
   function automatic logic [WORD_W-1:0] frame_word(input logic [FRAME_BITS-1:0] f,
                                                    input int unsigned idx);
      return f[FRAME_BITS-1-idx*WORD_W -: WORD_W];
   endfunction

endpackage

// File: rtl/spi_meas_reader_if.sv
// -----------------------------------------------------------------------------
// spi_meas_reader_if: host request/result signals plus the SPI bus to the meter.
//   req         host -> reader, single-cycle measure-and-read request
//   start_sig   reader -> meter, measurement start command
//   spi_sck     reader -> meter, SPI clock (idles low)
//   spi_cs_n    reader -> meter, chip select (active low)
//   spi_miso    meter -> reader, serial data
//   busy        reader -> host, request in progress
//   data_valid  reader -> host, one-cycle pulse when the counts update
//   fx_cnt, fbase_cnt, time_cnt, duty_cnt : reader -> host, latched results
// Modports: master = the reader, slave = host/meter side.
// -----------------------------------------------------------------------------
interface spi_meas_reader_if;
   import meas_pkg::*;

   logic              req;
   logic              start_sig;
   logic              spi_sck;
   logic              spi_cs_n;
   logic              spi_miso;
   logic              busy;
   logic              data_valid;
   logic [WORD_W-1:0] fx_cnt;
   logic [WORD_W-1:0] fbase_cnt;
   logic [WORD_W-1:0] time_cnt;
   logic [WORD_W-1:0] duty_cnt;

   modport master (
      input  req, spi_miso,
      output start_sig, spi_sck, spi_cs_n, busy, data_valid,
      output fx_cnt, fbase_cnt, time_cnt, duty_cnt
   );

   modport slave (
      output req, spi_miso,
      input  start_sig, spi_sck, spi_cs_n, busy, data_valid,
      input  fx_cnt, fbase_cnt, time_cnt, duty_cnt
   );

endinterface

// File: rtl/spi_meas_reader_sck_gen.sv
// -----------------------------------------------------------------------------
// spi_sck_gen: SPI clock divider for the measurement reader.
//   i_clk, i_rst : system clock, asynchronous active-high reset
//   i_en         : high only while shifting; low holds divider at 0 and SCK low
//   o_sck        : registered SCK, toggles every CLK_DIV cycles, first edge rising
//   o_fall       : high in the cycle whose closing edge drops SCK (end of high phase)
// -----------------------------------------------------------------------------
module spi_sck_gen #(
   parameter int unsigned CLK_DIV = 10
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_en,
   output logic o_sck,
   output logic o_fall
);

   localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);

   logic [7:0] r_div;
   logic       r_sck;
   logic       w_wrap;

   assign w_wrap = (r_div == DIV_M1);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_div <= '0;
         r_sck <= 1'b0;
      end else if (!i_en) begin
         // Parking at 0 makes the first half-period after enable full length.
         r_div <= '0;
         r_sck <= 1'b0;
      end else if (w_wrap) begin
         r_div <= '0;
         r_sck <= ~r_sck;
      end else begin
         r_div <= r_div + 8'd1;
      end
   end

   assign o_sck  = r_sck;
   assign o_fall = i_en & w_wrap & r_sck;

endmodule

// File: rtl/spi_meas_reader.sv
// -----------------------------------------------------------------------------
// spi_meas_reader: on a host request, pulses the meter's start_sig for GATE_WAIT
// cycles, then performs a 128-bit SPI mode-0 read and latches the four counts.
//   i_clk, i_rst : system clock, asynchronous active-high reset
//   bus          : spi_meas_reader_if.master (host handshake, SPI pins, results)
// Parameters: CLK_DIV (clk per SCK half-period, 4..255), GATE_WAIT (>=1),
//             CS_GAP (clk between cs_n and SCK activity, >=1).
// -----------------------------------------------------------------------------
module spi_meas_reader
   import meas_pkg::*;
#(
   parameter int unsigned CLK_DIV   = 10,
   parameter int unsigned GATE_WAIT = 60_000_000,
   parameter int unsigned CS_GAP    = 4
) (
   input logic                i_clk,
   input logic                i_rst,
   spi_meas_reader_if.master  bus
);

   localparam logic [31:0] GW_M1   = 32'(GATE_WAIT - 1);
   localparam logic [31:0] GAP_M1  = 32'(CS_GAP - 1);
   localparam logic [6:0]  LAST_BIT = 7'(FRAME_BITS - 1);

   meas_state_e           r_state;
   logic [31:0]           r_cnt;
   logic [6:0]            r_bit_cnt;
   logic [FRAME_BITS-1:0] r_shift;
   logic                  r_start;
   logic                  r_cs_n;
   logic                  r_busy;
   logic                  r_valid;
   logic [WORD_W-1:0]     r_fx;
   logic [WORD_W-1:0]     r_fbase;
   logic [WORD_W-1:0]     r_time;
   logic [WORD_W-1:0]     r_duty;
   logic                  r_miso_s1;
   logic                  r_miso_s2;
   logic                  w_sck;
   logic                  w_fall;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_miso_s1 <= 1'b0;
         r_miso_s2 <= 1'b0;
      end else begin
         r_miso_s1 <= bus.spi_miso;
         r_miso_s2 <= r_miso_s1;
      end
   end

   spi_sck_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_sck_gen (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_en   (r_state == StShift),
      .o_sck  (w_sck),
      .o_fall (w_fall)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state   <= StIdle;
         r_cnt     <= '0;
         r_bit_cnt <= '0;
         r_shift   <= '0;
         r_start   <= 1'b0;
         r_cs_n    <= 1'b1;
         r_busy    <= 1'b0;
         r_valid   <= 1'b0;
         r_fx      <= '0;
         r_fbase   <= '0;
         r_time    <= '0;
         r_duty    <= '0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            StIdle: begin
               if (bus.req) begin
                  r_state <= StArm;
                  r_busy  <= 1'b1;
                  r_start <= 1'b1;
                  r_cnt   <= '0;
               end
            end
            StArm: begin
               if (r_cnt == GW_M1) begin
                  r_start <= 1'b0;
                  r_cs_n  <= 1'b0;
                  r_cnt   <= '0;
                  r_state <= StCsLead;
               end else begin
                  r_cnt <= r_cnt + 32'd1;
               end
            end
            StCsLead: begin
               if (r_cnt == GAP_M1) begin
                  r_cnt     <= '0;
                  r_bit_cnt <= '0;
                  r_state   <= StShift;
               end else begin
                  r_cnt <= r_cnt + 32'd1;
               end
            end
            StShift: begin
               // Sampling at the end of the high phase leaves a full half-period for
               // the slave's post-fall update plus the two synchronizer stages.
               if (w_fall) begin
                  r_shift   <= {r_shift[FRAME_BITS-2:0], r_miso_s2};
                  r_bit_cnt <= r_bit_cnt + 7'd1;
                  if (r_bit_cnt == LAST_BIT) begin
                     r_state <= StCsTrail;
                  end
               end
            end
            StCsTrail: begin
               if (r_cnt == GAP_M1) begin
                  r_cnt   <= '0;
                  r_cs_n  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_valid <= 1'b1;
                  r_fx    <= frame_word(r_shift, FX);
                  r_fbase <= frame_word(r_shift, FBASE);
                  r_time  <= frame_word(r_shift, TIME);
                  r_duty  <= frame_word(r_shift, DUTY);
                  r_state <= StDone;
               end else begin
                  r_cnt <= r_cnt + 32'd1;
               end
            end
            StDone: begin
               r_state <= StIdle;
            end
            default: begin
               r_state <= StIdle;
            end
         endcase
      end
   end

   assign bus.start_sig  = r_start;
   assign bus.spi_sck    = w_sck;
   assign bus.spi_cs_n   = r_cs_n;
   assign bus.busy       = r_busy;
   assign bus.data_valid = r_valid;
   assign bus.fx_cnt     = r_fx;
   assign bus.fbase_cnt  = r_fbase;
   assign bus.time_cnt   = r_time;
   assign bus.duty_cnt   = r_duty;

endmodule

// File: tb/tb_spi_meas_reader.sv
// -----------------------------------------------------------------------------
// tb_spi_meas_reader: directed bench for spi_meas_reader with a clocked SPI
// slave model that shifts out a 128-bit frame, updating MISO a configurable
// number of clk cycles after each SCK falling edge.
// -----------------------------------------------------------------------------
module tb_spi_meas_reader;

   localparam int CLK_DIV   = 4;
   localparam int GATE_WAIT = 20;
   localparam int CS_GAP    = 4;
   localparam int LAT       = 1 + GATE_WAIT + CS_GAP + 256 * CLK_DIV + CS_GAP + 1;

   logic clk;
   logic rst;

   spi_meas_reader_if bus ();

   spi_meas_reader #(
      .CLK_DIV   (CLK_DIV),
      .GATE_WAIT (GATE_WAIT),
      .CS_GAP    (CS_GAP)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   // Slave model state.
   logic [127:0] tx         = '0;
   int           miso_dly   = 1;
   int           bit_idx    = 127;
   int           pend       = -1;
   logic         s_prev_sck = 1'b0;
   logic [127:0] last_frame = '0;

   always @(posedge clk) begin
      if (bus.spi_cs_n) begin
         bit_idx = 127;
         pend    = -1;
      end else begin
         if (s_prev_sck && !bus.spi_sck) pend = miso_dly - 1;
         if (pend == 0 && bit_idx > 0) bit_idx = bit_idx - 1;
         if (pend >= 0) pend = pend - 1;
      end
      s_prev_sck = bus.spi_sck;
      bus.spi_miso <= tx[bit_idx];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
      end
   endtask

   task automatic run_frame(input logic [127:0] frame, input int dly, input bit extra,
                            input string nm);
      int   start_hi, rises, dvs, busy_err, idle_err, gap_err, hold_err, dv_k;
      int   last_cs_k, last_sck_k;
      logic prev_sck, prev_cs, seen;
      start_hi = 0; rises = 0; dvs = 0; busy_err = 0; idle_err = 0; gap_err = 0;
      hold_err = 0; dv_k = -10; last_cs_k = -1000; last_sck_k = -1000;
      prev_sck = 1'b0; prev_cs = 1'b1; seen = 1'b0;
      tx = frame;
      miso_dly = dly;
      bus.req = 1'b1;
      @(posedge clk); #1;
      bus.req = 1'b0;
      for (int k = 0; k < 1100; k++) begin
         if (bus.start_sig) start_hi++;
         if (bus.spi_sck && !prev_sck) rises++;
         if (bus.spi_sck && bus.spi_cs_n) idle_err++;
         if (bus.spi_cs_n != prev_cs) begin
            if (k - last_sck_k < CS_GAP) gap_err++;
            last_cs_k = k;
         end
         if (bus.spi_sck != prev_sck) begin
            if (k - last_cs_k < CS_GAP) gap_err++;
            last_sck_k = k;
         end
         if (bus.data_valid) begin
            dvs++;
            if (!seen) dv_k = k;
            if (bus.busy) busy_err++;
         end else if (!seen) begin
            if (!bus.busy) busy_err++;
            if ({bus.fx_cnt, bus.fbase_cnt, bus.time_cnt, bus.duty_cnt} !== last_frame)
               hold_err++;
         end else if (bus.busy) begin
            busy_err++;
         end
         // Extra requests land in ARM, in SHIFT and in the DONE cycle.
         bus.req = extra && (k == 5 || k == 300 || (bus.data_valid && !seen));
         if (bus.data_valid) seen = 1'b1;
         prev_sck = bus.spi_sck;
         prev_cs  = bus.spi_cs_n;
         @(posedge clk); #1;
      end
      bus.req = 1'b0;
      chk({nm, " latency"}, 32'(dv_k + 2), 32'(LAT));
      chk({nm, " start_sig cycles"}, 32'(start_hi), 32'(GATE_WAIT));
      chk({nm, " sck rises"}, 32'(rises), 32'd128);
      chk({nm, " data_valid pulses"}, 32'(dvs), 32'd1);
      chk({nm, " busy errors"}, 32'(busy_err), 32'd0);
      chk({nm, " sck while cs_n high"}, 32'(idle_err), 32'd0);
      chk({nm, " cs gap errors"}, 32'(gap_err), 32'd0);
      chk({nm, " hold errors"}, 32'(hold_err), 32'd0);
      chk({nm, " fx_cnt"}, bus.fx_cnt, frame[127 -: 32]);
      chk({nm, " fbase_cnt"}, bus.fbase_cnt, frame[95 -: 32]);
      chk({nm, " time_cnt"}, bus.time_cnt, frame[63 -: 32]);
      chk({nm, " duty_cnt"}, bus.duty_cnt, frame[31 -: 32]);
      last_frame = frame;
   endtask

   initial begin
      int   rises;
      logic prev_sck;
      logic [127:0] frame_a;
      logic [127:0] frame_c;
      frame_a = {32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F, 32'h80000001};
      frame_c = {32'hDEADBEEF, 32'h01234567, 32'hA5A5A5A5, 32'h7FFFFFFE};

      rst = 1'b1;
      bus.req = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset start_sig", 32'(bus.start_sig), 32'd0);
      chk("reset spi_sck", 32'(bus.spi_sck), 32'd0);
      chk("reset spi_cs_n", 32'(bus.spi_cs_n), 32'd1);
      chk("reset busy", 32'(bus.busy), 32'd0);
      chk("reset data_valid", 32'(bus.data_valid), 32'd0);
      chk("reset fx_cnt", bus.fx_cnt, 32'd0);
      chk("reset duty_cnt", bus.duty_cnt, 32'd0);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      run_frame(frame_a, 1, 1'b0, "frame A");
      run_frame({128{1'b1}}, 1, 1'b0, "all ones");
      run_frame(128'd0, 1, 1'b0, "all zeros");
      run_frame(frame_a, 1, 1'b1, "ignored reqs");

      // Abandon a frame around bit 60 with an asynchronous reset.
      tx = frame_c;
      miso_dly = 1;
      rises = 0;
      prev_sck = 1'b0;
      bus.req = 1'b1;
      @(posedge clk); #1;
      bus.req = 1'b0;
      for (int k = 0; k < 1000 && rises < 60; k++) begin
         @(posedge clk); #1;
         if (bus.spi_sck && !prev_sck) rises++;
         prev_sck = bus.spi_sck;
      end
      chk("mid-frame rises reached", 32'(rises), 32'd60);
      #3 rst = 1'b1;
      #1;
      chk("async rst spi_cs_n", 32'(bus.spi_cs_n), 32'd1);
      chk("async rst spi_sck", 32'(bus.spi_sck), 32'd0);
      chk("async rst busy", 32'(bus.busy), 32'd0);
      chk("async rst fx_cnt", bus.fx_cnt, 32'd0);
      chk("async rst fbase_cnt", bus.fbase_cnt, 32'd0);
      chk("async rst time_cnt", bus.time_cnt, 32'd0);
      chk("async rst duty_cnt", bus.duty_cnt, 32'd0);
      last_frame = '0;
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      run_frame(frame_c, 3, 1'b0, "delayed miso");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
